// File: rtl/tb_trace_pkg.sv
// Shared types for the retire trace path: retire entry layout and lane count.
package tb_trace_pkg;

    localparam int NUM_RETIRE = 3;

    typedef struct packed {
        logic [1:0]  idx;
        logic [63:0] pc;
        logic [31:0] seq;
    } retire_entry_t;

    // Number of set bits in a retire valid vector.
    function automatic logic [1:0] popcnt3(input logic [NUM_RETIRE-1:0] v);
        return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
    endfunction

endpackage

// File: rtl/tb_mw_fifo.sv
// Flop FIFO of retire entries: up to NUM_RETIRE writes and one read per cycle.
// The writer must never present more than 'free' entries.
module tb_mw_fifo
    import tb_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic                             clk,
    input  logic                             rst_b,
    input  logic                             clr,
    input  logic [1:0]                       wr_cnt,
    input  retire_entry_t [NUM_RETIRE-1:0]   wr_data,
    input  logic                             rd_en,
    output retire_entry_t                    rd_data,
    output logic [LW-1:0]                    level,
    output logic [LW-1:0]                    free
);

    retire_entry_t mem [DEPTH];
    logic [LW-1:0] wr_ptr;
    logic [LW-1:0] rd_ptr;
    logic          pop;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign level   = wr_ptr - rd_ptr;
    assign pop     = rd_en && (level != '0);
    assign free    = LW'(DEPTH) - level + LW'(pop);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; clear wins over any same-cycle traffic.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + LW'(wr_cnt);
            rd_ptr <= rd_ptr + LW'(pop);
        end
    end

    // Storage write: packed entries land in consecutive slots from wr_ptr.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_RETIRE; i++) begin
            if (!clr && (2'(i) < wr_cnt))
                mem[wr_ptr[AW-1:0] + AW'(i)] <= wr_data[i];
        end
    end

endmodule

// File: rtl/tb_retire_commit_queue.sv
// Retire commit queue: compacts the three retire ports into program order,
// tags each retirement with a sequence number and buffers them for the
// commit-check stage. Tracks drops on overflow and a no-retire watchdog.
module tb_retire_commit_queue
    import tb_trace_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int PC_W        = 40,
    parameter int WDOG_CYCLES = 50000,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       rst_b,
    input  logic                       clr,
    input  logic [NUM_RETIRE-1:0]      retire_vld,
    input  logic [NUM_RETIRE*PC_W-1:0] retire_pc,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic [1:0]                 out_idx,
    output logic [63:0]                out_pc,
    output logic [31:0]                out_seq,
    output logic [LW-1:0]              level,
    output logic [31:0]                drop_cnt,
    output logic                       overflow,
    output logic                       wdog_expired
);

    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_CYCLES - 1);

    retire_entry_t [NUM_RETIRE-1:0] lane_ent;
    logic [NUM_RETIRE-1:0][1:0]     lane_pos;
    retire_entry_t [NUM_RETIRE-1:0] wr_data;
    retire_entry_t                  head;
    logic [LW-1:0]                  free;
    logic [1:0]                     n;
    logic [1:0]                     wr_cnt;
    logic [1:0]                     dropped;
    logic [32:0]                    drop_sum;
    logic [31:0]                    seq_cnt;
    logic [WD_W-1:0]                wd_cnt;

    // Per-lane entry and its slot in the packed order (count of valid lanes below it).
    for (genvar k = 0; k < NUM_RETIRE; k++) begin : g_lane
        assign lane_pos[k]     = popcnt3(retire_vld & 3'((1 << k) - 1));
        assign lane_ent[k].idx = 2'(k);
        assign lane_ent[k].pc  = 64'(retire_pc[k*PC_W +: PC_W]);
        assign lane_ent[k].seq = seq_cnt + 32'(lane_pos[k]);
    end

    // Pack valid lanes into ascending write slots.
    always_comb begin
        wr_data = '0;
        for (int k = 0; k < NUM_RETIRE; k++) begin
            if (retire_vld[k])
                wr_data[lane_pos[k]] = lane_ent[k];
        end
    end

    assign n        = popcnt3(retire_vld);
    assign wr_cnt   = (LW'(n) <= free) ? n : free[1:0];
    assign dropped  = n - wr_cnt;
    assign drop_sum = {1'b0, drop_cnt} + 33'(dropped);

    tb_mw_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_b   (rst_b),
        .clr     (clr),
        .wr_cnt  (wr_cnt),
        .wr_data (wr_data),
        .rd_en   (out_rdy),
        .rd_data (head),
        .level   (level),
        .free    (free)
    );

    // Head presentation; data is forced to zero while empty so reset/clear show all zeros.
    assign out_vld = (level != '0);
    assign out_idx = out_vld ? head.idx : '0;
    assign out_pc  = out_vld ? head.pc  : '0;
    assign out_seq = out_vld ? head.seq : '0;

    // Sequence numbering and drop accounting; dropped retirements still consume seq numbers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            seq_cnt  <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            seq_cnt  <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            seq_cnt  <= seq_cnt + 32'(n);
            drop_cnt <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
            if (dropped != '0)
                overflow <= 1'b1;
        end
    end

    // No-retire watchdog: counter saturates, expiry is sticky until reset/clear.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wd_cnt       <= '0;
            wdog_expired <= 1'b0;
        end else if (clr) begin
            wd_cnt       <= '0;
            wdog_expired <= 1'b0;
        end else if (retire_vld != '0) begin
            wd_cnt <= '0;
        end else if (wd_cnt == WD_MAX) begin
            wdog_expired <= 1'b1;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_tb_retire_commit_queue.sv
// Bench for the retire commit queue: directed scenarios plus random traffic,
// every cycle compared against a queue-based reference model.
module tb_tb_retire_commit_queue;

    localparam int DEPTH = 16;
    localparam int PC_W  = 40;
    localparam int WDOG  = 50;

    typedef struct packed {
        logic [1:0]  idx;
        logic [63:0] pc;
        logic [31:0] seq;
    } ment_t;

    logic         clk = 1'b0;
    logic         rst_b;
    logic         clr;
    logic [2:0]   retire_vld;
    logic [119:0] retire_pc;
    logic         out_vld;
    logic         out_rdy;
    logic [1:0]   out_idx;
    logic [63:0]  out_pc;
    logic [31:0]  out_seq;
    logic [4:0]   level;
    logic [31:0]  drop_cnt;
    logic         overflow;
    logic         wdog_expired;

    int ntests = 0;
    int nfail  = 0;

    ment_t       mq[$];
    logic [31:0] mseq;
    int          mdrop;
    bit          movf;
    int          midle;
    bit          mexp;

    tb_retire_commit_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .WDOG_CYCLES(WDOG)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .clr          (clr),
        .retire_vld   (retire_vld),
        .retire_pc    (retire_pc),
        .out_vld      (out_vld),
        .out_rdy      (out_rdy),
        .out_idx      (out_idx),
        .out_pc       (out_pc),
        .out_seq      (out_seq),
        .level        (level),
        .drop_cnt     (drop_cnt),
        .overflow     (overflow),
        .wdog_expired (wdog_expired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mseq = 0; mdrop = 0; movf = 0; midle = 0; mexp = 0;
    endtask

    // Reference: pop first (frees a slot), then accept valid ports in order while room remains.
    task automatic model_update(input logic [2:0] v, input logic [119:0] p, input logic r, input logic c);
        ment_t e;
        if (c) begin
            model_reset();
            return;
        end
        if (r && mq.size() > 0) e = mq.pop_front();
        for (int k = 0; k < 3; k++) begin
            if (v[k]) begin
                if (mq.size() < DEPTH) begin
                    e.idx = 2'(k);
                    e.pc  = 64'(p[k*PC_W +: PC_W]);
                    e.seq = mseq;
                    mq.push_back(e);
                end else begin
                    mdrop++;
                    movf = 1;
                end
                mseq++;
            end
        end
        if (v != 0) midle = 0;
        else begin
            midle++;
            if (midle >= WDOG) mexp = 1;
        end
    endtask

    task automatic check_outputs();
        chk("out_vld", out_vld, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("out_idx", out_idx, mq[0].idx);
            chk("out_pc",  out_pc,  mq[0].pc);
            chk("out_seq", out_seq, mq[0].seq);
        end
        chk("level",    level,        mq.size());
        chk("drop_cnt", drop_cnt,     mdrop);
        chk("overflow", overflow,     movf);
        chk("wdog",     wdog_expired, mexp);
    endtask

    // One clock: apply inputs, compare outputs, advance both DUT and model.
    task automatic step(input logic [2:0] v, input logic [119:0] p, input logic r, input logic c);
        retire_vld = v; retire_pc = p; out_rdy = r; clr = c;
        #1;
        check_outputs();
        @(posedge clk);
        model_update(v, p, r, c);
        #1;
    endtask

    function automatic logic [119:0] pcs(input logic [39:0] a, input logic [39:0] b, input logic [39:0] c);
        return {c, b, a};
    endfunction

    function automatic logic [119:0] rand_pcs();
        logic [119:0] p;
        logic [39:0]  x;
        for (int k = 0; k < 3; k++) begin
            x = {8'($urandom), 32'($urandom)};
            p[k*PC_W +: PC_W] = x;
        end
        return p;
    endfunction

    initial begin
        logic [2:0]  v;
        logic        r;
        logic [1:0]  h_idx;
        logic [63:0] h_pc;
        logic [31:0] h_seq;
        logic [31:0] last_seq;
        bit          have_last;
        bit          stalled;
        int          total;
        int          accepted;

        rst_b = 1'b0; clr = 1'b0; retire_vld = '0; retire_pc = '0; out_rdy = 1'b0;
        model_reset();
        #2;
        check_outputs();
        chk("rst_pc", out_pc, 0);
        #10 rst_b = 1'b1;

        // Single retire with ready high
        step(3'b001, pcs(40'h80000000, 0, 0), 1'b1, 1'b0);
        chk("single_vld", out_vld, 1);
        chk("single_idx", out_idx, 0);
        chk("single_pc",  out_pc,  64'h80000000);
        chk("single_seq", out_seq, 0);
        step(3'b000, '0, 1'b1, 1'b0);
        chk("single_lvl", level, 0);

        // Compaction of ports 0 and 2
        step(3'b000, '0, 1'b0, 1'b1);
        step(3'b101, pcs(40'h100, 40'h999, 40'h108), 1'b0, 1'b0);
        chk("cmp_lvl",  level,   2);
        chk("cmp_idx0", out_idx, 0);
        chk("cmp_pc0",  out_pc,  64'h100);
        chk("cmp_seq0", out_seq, 0);
        step(3'b000, '0, 1'b1, 1'b0);
        chk("cmp_idx1", out_idx, 2);
        chk("cmp_pc1",  out_pc,  64'h108);
        chk("cmp_seq1", out_seq, 1);
        step(3'b000, '0, 1'b1, 1'b0);
        chk("cmp_empty", level, 0);

        // Overflow: 18 retirements into a 16-deep FIFO
        step(3'b000, '0, 1'b0, 1'b1);
        repeat (6) step(3'b111, rand_pcs(), 1'b0, 1'b0);
        chk("ovf_lvl",  level,    16);
        chk("ovf_drop", drop_cnt, 2);
        chk("ovf_flag", overflow, 1);
        for (int i = 0; i < 16; i++) begin
            chk("ovf_drain_seq", out_seq, i);
            step(3'b000, '0, 1'b1, 1'b0);
        end
        step(3'b001, pcs(40'h42, 0, 0), 1'b0, 1'b0);
        chk("ovf_next_seq", out_seq, 18);

        // Full FIFO with simultaneous pop and two retirements
        step(3'b000, '0, 1'b0, 1'b1);
        repeat (5) step(3'b111, rand_pcs(), 1'b0, 1'b0);
        step(3'b001, rand_pcs(), 1'b0, 1'b0);
        chk("full_lvl0",  level,    16);
        chk("full_drop0", drop_cnt, 0);
        step(3'b011, rand_pcs(), 1'b1, 1'b0);
        chk("full_lvl1",  level,    16);
        chk("full_drop1", drop_cnt, 1);
        chk("full_head",  out_seq,  1);

        // Watchdog: 49 idle cycles quiet, 50th fires; a retire restarts the count
        step(3'b000, '0, 1'b0, 1'b1);
        repeat (49) step(3'b000, '0, 1'b0, 1'b0);
        chk("wd_49", wdog_expired, 0);
        step(3'b000, '0, 1'b0, 1'b0);
        chk("wd_50", wdog_expired, 1);
        step(3'b000, '0, 1'b0, 1'b1);
        chk("wd_clr", wdog_expired, 0);
        repeat (30) step(3'b000, '0, 1'b0, 1'b0);
        step(3'b001, rand_pcs(), 1'b0, 1'b0);
        repeat (49) step(3'b000, '0, 1'b0, 1'b0);
        chk("wd_restart_49", wdog_expired, 0);
        step(3'b000, '0, 1'b0, 1'b0);
        chk("wd_restart_50", wdog_expired, 1);

        // Random traffic with random backpressure, then a full drain
        step(3'b000, '0, 1'b0, 1'b1);
        total = 0; accepted = 0; have_last = 0; last_seq = 0;
        for (int c = 0; c < 1020; c++) begin
            v = (c < 1000) ? 3'($urandom) : 3'b000;
            r = (c < 1000) ? ($urandom_range(3, 0) != 0) : 1'b1;
            for (int k = 0; k < 3; k++) total += int'(v[k]);
            stalled = out_vld && !r;
            h_idx = out_idx; h_pc = out_pc; h_seq = out_seq;
            if (out_vld && r) begin
                chk("seq_incr", (!have_last || out_seq > last_seq), 1);
                last_seq = out_seq; have_last = 1; accepted++;
            end
            step(v, rand_pcs(), r, 1'b0);
            if (stalled) begin
                chk("hold_idx", out_idx, h_idx);
                chk("hold_pc",  out_pc,  h_pc);
                chk("hold_seq", out_seq, h_seq);
            end
        end
        chk("drain_empty", level, 0);
        chk("seq_gap", accepted + drop_cnt, total);

        // Asynchronous reset in the middle of traffic discards everything
        repeat (4) step(3'b111, rand_pcs(), 1'b0, 1'b0);
        rst_b = 1'b0;
        #2;
        model_reset();
        check_outputs();
        chk("arst_seq", out_seq, 0);
        #2 rst_b = 1'b1;
        step(3'b000, '0, 1'b1, 1'b0);
        step(3'b010, pcs(0, 40'h77, 0), 1'b1, 1'b0);
        chk("arst_after_seq", out_seq, 0);
        chk("arst_after_idx", out_idx, 1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
